// File: rtl/obi_slave_cut_pkg.sv
// Shared OBI request/response types and the sizing helper for the
// registered slave-port isolation stage.
package obi_slave_cut_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    // Request payload as held in the request buffer (no handshake bit).
    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_payload_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/obi_slave_cut_fifo.sv
// Non-fall-through FIFO: the head is visible on data_o while not empty,
// pushes become visible the cycle after they are written.
module obi_slave_cut_fifo
    import obi_slave_cut_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned PW = idx_width(DEPTH);
    localparam int unsigned CW = idx_width(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/obi_slave_cut.sv
// Registered OBI cut between crossbar and external slave: request buffer,
// response FIFO, and credit-based admission so rvalid always has space.
module obi_slave_cut
    import obi_slave_cut_pkg::*;
#(
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  obi_req_t  slv_req_i,
    output obi_resp_t slv_resp_o,
    output obi_req_t  mst_req_o,
    input  obi_resp_t mst_resp_i
);
    localparam int unsigned REQ_DEPTH = 2;
    localparam int unsigned CNT_W     = idx_width(RSP_DEPTH + 1);

    obi_payload_t     req_in, req_head;
    logic             req_empty, req_full;
    logic [31:0]      rsp_head;
    logic             rsp_empty, rsp_full;
    logic             accept, deliver;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;

    // Grant sees only upstream req and registered occupancy/credit.
    assign accept  = slv_req_i.req && !req_full && (outstanding_q < CNT_W'(RSP_DEPTH));
    assign deliver = !rsp_empty;

    assign req_in = '{we: slv_req_i.we, be: slv_req_i.be,
                      addr: slv_req_i.addr, wdata: slv_req_i.wdata};

    obi_slave_cut_fifo #(.DEPTH(REQ_DEPTH), .WIDTH($bits(obi_payload_t))) u_req_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept),
        .data_i  (req_in),
        .pop_i   (mst_resp_i.gnt),
        .data_o  (req_head),
        .empty_o (req_empty),
        .full_o  (req_full)
    );

    obi_slave_cut_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(32)) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (mst_resp_i.rvalid),
        .data_i  (mst_resp_i.rdata),
        .pop_i   (deliver),
        .data_o  (rsp_head),
        .empty_o (rsp_empty),
        .full_o  (rsp_full)
    );

    always_comb begin
        outstanding_d = outstanding_q;
        if (accept && !deliver) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!accept && deliver) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    // Payload and rdata are forced to zero when their FIFO is empty.
    always_comb begin
        slv_resp_o        = '0;
        slv_resp_o.gnt    = accept;
        slv_resp_o.rvalid = deliver;
        slv_resp_o.rdata  = deliver ? rsp_head : '0;
        mst_req_o         = '0;
        if (!req_empty) begin
            mst_req_o.req   = 1'b1;
            mst_req_o.we    = req_head.we;
            mst_req_o.be    = req_head.be;
            mst_req_o.addr  = req_head.addr;
            mst_req_o.wdata = req_head.wdata;
        end
    end

    a_rvalid_has_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mst_resp_i.rvalid |-> (outstanding_q != '0));
    a_rvalid_has_space: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mst_resp_i.rvalid |-> !rsp_full);
    a_credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        outstanding_q <= CNT_W'(RSP_DEPTH));

endmodule

// File: tb/tb_obi_slave_cut.sv
// Directed and random bench for obi_slave_cut: a bench-side in-order slave
// with its own memory, and a transaction-level model of what the crossbar sees.
module tb_obi_slave_cut;
    import obi_slave_cut_pkg::*;

    localparam int RSP_DEPTH = 4;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    obi_req_t  slv_req, mst_req;
    obi_resp_t slv_resp, mst_resp;

    always #5 clk = ~clk;

    obi_slave_cut #(.RSP_DEPTH(RSP_DEPTH)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp)
    );

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;
    typedef struct {
        logic [31:0] data;
        int          ready;
    } srsp_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    txn_t        down_q[$];   // accepted upstream, not yet granted downstream
    logic [31:0] exp_q[$];    // expected upstream responses in request order
    srsp_t       slv_q[$];    // granted at the slave, response not yet given
    logic [31:0] ref_mem[16];
    logic [31:0] slv_mem[16];
    int slave_rv = 0, delivered = 0;
    int gnt_pct = 100, rv_pct = 100, max_lat = 0;
    int stall_until = -1, hold_until = -1;
    int acc_log[$];
    int first_rv = -1, first_mreq = -1;
    logic acc_now = 1'b0;
    logic [31:0] last_rdata = '0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Reference: the response each request must eventually produce, in order.
    function automatic logic [31:0] ref_resp(input txn_t t);
        logic [3:0] i = t.addr[5:2];
        if (t.we) begin
            ref_mem[i] = merge(ref_mem[i], t.wdata, t.be);
            return 32'h0;
        end
        return ref_mem[i];
    endfunction

    task automatic step();
        txn_t t;
        srsp_t s;
        logic [3:0] i;
        int pend;
        mst_resp.gnt    = (cyc >= stall_until) && (int'($urandom_range(99)) < gnt_pct);
        mst_resp.rvalid = 1'b0;
        mst_resp.rdata  = 32'h0;
        if (slv_q.size() > 0 && slv_q[0].ready <= cyc && cyc >= hold_until &&
            int'($urandom_range(99)) < rv_pct) begin
            mst_resp.rvalid = 1'b1;
            mst_resp.rdata  = slv_q[0].data;
        end
        @(negedge clk);
        check("up_gnt", 96'(slv_resp.gnt),
              96'(slv_req.req && down_q.size() < 2 && exp_q.size() < RSP_DEPTH));
        check("dn_req", 96'(mst_req.req), 96'(down_q.size() > 0));
        if (down_q.size() > 0) begin
            check("dn_we", 96'(mst_req.we), 96'(down_q[0].we));
            check("dn_be", 96'(mst_req.be), 96'(down_q[0].be));
            check("dn_addr", 96'(mst_req.addr), 96'(down_q[0].addr));
            check("dn_wdata", 96'(mst_req.wdata), 96'(down_q[0].wdata));
        end else begin
            check("dn_idle", 96'(mst_req), 96'(0));
        end
        pend = slave_rv - delivered;
        check("up_rvalid", 96'(slv_resp.rvalid), 96'(pend > 0));
        if (slv_resp.rvalid && exp_q.size() > 0) begin
            check("up_rdata", 96'(slv_resp.rdata), 96'(exp_q.pop_front()));
            delivered++;
            last_rdata = slv_resp.rdata;
            if (first_rv < 0) first_rv = cyc;
        end
        if (mst_req.req && first_mreq < 0) first_mreq = cyc;
        if (mst_req.req && mst_resp.gnt && down_q.size() > 0) begin
            t = down_q.pop_front();
            i = t.addr[5:2];
            s.data = t.we ? 32'h0 : slv_mem[i];
            if (t.we) slv_mem[i] = merge(slv_mem[i], t.wdata, t.be);
            s.ready = cyc + 1 + int'($urandom_range(max_lat));
            slv_q.push_back(s);
        end
        if (mst_resp.rvalid) begin
            void'(slv_q.pop_front());
            slave_rv++;
        end
        if (slv_req.req && slv_resp.gnt) begin
            t = '{we: slv_req.we, be: slv_req.be, addr: slv_req.addr, wdata: slv_req.wdata};
            down_q.push_back(t);
            exp_q.push_back(ref_resp(t));
            acc_log.push_back(cyc);
            acc_now = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input logic we, input logic [3:0] idx, input logic [31:0] wdata,
                         input logic [3:0] be);
        int n = 0;
        slv_req.req   = 1'b1;
        slv_req.we    = we;
        slv_req.be    = be;
        slv_req.addr  = 32'h2000_0000 + {26'd0, idx, 2'b00};
        slv_req.wdata = wdata;
        acc_now = 1'b0;
        while (!acc_now && n < 100) begin
            step();
            n++;
        end
        if (!acc_now) check("accept_timeout", 96'(0), 96'(1));
        slv_req.req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() > 0 || down_q.size() > 0 || slv_q.size() > 0) && n < 300) begin
            step();
            n++;
        end
        check("drain_timeout", 96'(n < 300), 96'(1));
    endtask

    task automatic wait_rv();
        int n = 0;
        while (first_rv < 0 && n < 50) begin
            step();
            n++;
        end
        check("rvalid_timeout", 96'(first_rv >= 0), 96'(1));
    endtask

    initial begin
        int s, n_in, d0;
        slv_req  = '0;
        mst_resp = '0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            slv_mem[i] = ref_mem[i];
        end
        ref_mem[4] = 32'hDEAD_BEEF;
        slv_mem[4] = 32'hDEAD_BEEF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_slv_resp", 96'(slv_resp), 96'(0));
        check("rst_mst_req", 96'(mst_req), 96'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single read: downstream req at N+1, upstream rvalid at N+3.
        acc_log.delete();
        first_rv = -1;
        first_mreq = -1;
        issue(1'b0, 4'd4, 32'h0, 4'hF);
        wait_rv();
        check("rd_req_latency", 96'(first_mreq - acc_log[0]), 96'(1));
        check("rd_rsp_latency", 96'(first_rv - acc_log[0]), 96'(3));
        check("rd_data", 96'(last_rdata), 96'(32'hDEAD_BEEF));
        drain();
        $display("txn single_read accept=%0d rvalid=%0d data=%h", acc_log[0], first_rv, last_rdata);

        // Eight back-to-back writes with a continuously granting slave.
        acc_log.delete();
        d0 = delivered;
        for (int k = 0; k < 8; k++) issue(1'b1, 4'(k), 32'(k), 4'hF);
        check("b2b_span", 96'(acc_log[7] - acc_log[0]), 96'(7));
        drain();
        check("b2b_rvalids", 96'(delivered - d0), 96'(8));
        $display("txn back_to_back first=%0d last=%0d rsp=%0d", acc_log[0], acc_log[7], delivered - d0);

        // Downstream stall of 5 cycles: buffer fills after 2 accepts.
        acc_log.delete();
        s = cyc;
        stall_until = cyc + 5;
        for (int k = 0; k < 3; k++) issue(1'b1, 4'(8 + k), $urandom, 4'hF);
        n_in = 0;
        foreach (acc_log[j]) if (acc_log[j] < s + 5) n_in++;
        check("stall_accepts", 96'(n_in), 96'(2));
        check("stall_resume", 96'(acc_log[2]), 96'(s + 6));
        drain();
        $display("txn stall accepts_in_stall=%0d resume=%0d", n_in, acc_log[2] - s);

        // Credit exhaustion: responses withheld for 10 cycles.
        acc_log.delete();
        first_rv = -1;
        s = cyc;
        hold_until = cyc + 10;
        d0 = delivered;
        for (int k = 0; k < 6; k++) issue(1'b0, 4'(k), 32'h0, 4'hF);
        n_in = 0;
        foreach (acc_log[j]) if (acc_log[j] < s + 10) n_in++;
        check("credit_accepts", 96'(n_in), 96'(RSP_DEPTH));
        check("credit_resume", 96'(acc_log[RSP_DEPTH]), 96'(first_rv + 1));
        drain();
        check("credit_rvalids", 96'(delivered - d0), 96'(6));
        hold_until = -1;
        $display("txn credit accepts=%0d first_rv=%0d resume=%0d", n_in, first_rv - s, acc_log[RSP_DEPTH] - s);

        // Mid-operation reset with four transactions outstanding.
        hold_until = cyc + 1000;
        for (int k = 0; k < 3; k++) issue(1'b0, 4'(k), 32'h0, 4'hF);
        stall_until = cyc + 1000;
        issue(1'b0, 4'd3, 32'h0, 4'hF);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_slv_resp", 96'(slv_resp), 96'(0));
        check("async_rst_mst_req", 96'(mst_req), 96'(0));
        mst_resp = '0;
        down_q.delete();
        exp_q.delete();
        slv_q.delete();
        slave_rv = 0;
        delivered = 0;
        stall_until = -1;
        hold_until = -1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc += 4;
        first_rv = -1;
        issue(1'b0, 4'd4, 32'h0, 4'hF);
        wait_rv();
        check("post_rst_rd", 96'(last_rdata), 96'(32'd4));
        drain();
        $display("txn mid_reset fresh_read data=%h", last_rdata);

        // Randomized traffic under varying slave grant/response behaviour.
        for (int ph = 0; ph < 4; ph++) begin
            case (ph)
                0: begin gnt_pct = 100; rv_pct = 100; max_lat = 0; end
                1: begin gnt_pct = 70;  rv_pct = 60;  max_lat = 2; end
                2: begin gnt_pct = 40;  rv_pct = 90;  max_lat = 1; end
                default: begin gnt_pct = 90; rv_pct = 30; max_lat = 3; end
            endcase
            d0 = delivered;
            for (int k = 0; k < 80; k++) begin
                issue(1'($urandom), 4'($urandom), $urandom, 4'($urandom));
                if ($urandom_range(3) == 0) repeat ($urandom_range(2)) step();
            end
            drain();
            check("rand_rsp_count", 96'(delivered - d0), 96'(80));
            $display("txn random_phase=%0d responses=%0d", ph, delivered - d0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
